// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM states,
// stream framing constants and the header length check.
package prog_loader_pkg;

    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    // One extra bit so that a full-depth RAM (2**16 words) is still representable.
    function automatic logic len_exceeds(input logic [LEN_W-1:0] len, input int addr_w);
        logic [LEN_W:0] depth;
        depth = (LEN_W+1)'(1) << addr_w;
        return {1'b0, len} > depth;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and RAM write port out; the loader uses the slave view,
// the byte source and RAM side use the master view.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) ();

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Assembles four stream bytes into a 32-bit word, first byte landing in the MSBs.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              last_o,
    output logic              word_full_o
);

    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] word_q;
    logic              full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else if (shift_i) begin
            word_q <= {word_q[DATA_W-9:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
            full_q <= last_o;
        end
    end

    assign last_o      = (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o      = word_q;
    assign word_full_o = full_q;

endmodule

// File: rtl/prog_loader.sv
// Fills the CPU's RAM from a length-prefixed byte stream, then releases
// the CPU from reset once every word has been written.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              xfer;
    logic [LEN_W-1:0]  full_len;
    logic              pk_clear;
    logic              pk_shift;
    logic              pk_last;
    logic              pk_full;
    logic [DATA_W-1:0] pk_word;

    prog_loader_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (pk_clear),
        .shift_i     (pk_shift),
        .byte_i      (bus.byte_data),
        .word_o      (pk_word),
        .last_o      (pk_last),
        .word_full_o (pk_full)
    );

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign full_len = {len_q[LEN_W-1:8], bus.byte_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        pk_clear       = 1'b0;
        pk_shift       = 1'b0;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = LEN_HI;
            end
            LEN_HI: begin
                bus.byte_ready = 1'b1;
                if (xfer) begin
                    len_d   = {bus.byte_data, len_q[7:0]};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                bus.byte_ready = 1'b1;
                if (xfer) begin
                    len_d = full_len;
                    if (full_len == '0) begin
                        state_d = DONE;
                    end else if (len_exceeds(full_len, ADDR_W)) begin
                        state_d = ERR;
                    end else begin
                        idx_d    = '0;
                        pk_clear = 1'b1;
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                bus.byte_ready = 1'b1;
                if (xfer) begin
                    pk_shift = 1'b1;
                    if (pk_last) state_d = WRITE;
                end
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                addr_d     = idx_q[ADDR_W-1:0];
                wdata_d    = pk_word;
                pk_clear   = 1'b1;
                // The index never wraps: a full-depth load ends on the last address.
                if ({1'b0, idx_q} == ({1'b0, len_q} - (LEN_W+1)'(1))) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DATA;
                end
            end
            DONE: begin
                if (start) state_d = LEN_HI;
            end
            ERR: begin
                if (start) state_d = LEN_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and data are live during WRITE and otherwise hold the last written word.
    assign bus.mem_addr  = (state_q == WRITE) ? idx_q[ADDR_W-1:0] : addr_q;
    assign bus.mem_wdata = pk_full ? pk_word : wdata_q;

    assign busy      = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                       (state_q == DATA)   || (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign cpu_rst_n = (state_q == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: header handling, word assembly, write timing,
// flow control, oversize rejection, restart and asynchronous reset.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_rst_n, busy, done, err;

    int checks = 0;
    int failures = 0;

    logic [39:0] wq[$];

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus.slave),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // {busy, done, err, cpu_rst_n, byte_ready, mem_we}
    function automatic logic [5:0] status();
        return {busy, done, err, cpu_rst_n, bus.byte_ready, bus.mem_we};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hEE;
        repeat (gap) begin @(posedge clk); #1; end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        waited = 0;
        while (bus.byte_ready !== 1'b1 && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: byte_ready=%b expected 1 for byte %h", bus.byte_ready, b);
        end else begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (status() !== 6'b000000) begin failures++; $display("FAIL reset_idle: status=%b expected 000000", status()); end
        checks++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus: addr=%h data=%h expected 00 00000000", bus.mem_addr, bus.mem_wdata); end
        pulse_start();
        checks++;
        if (status() !== 6'b100010) begin failures++; $display("FAIL reset_lenhi: status=%b expected 100010", status()); end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (status() !== 6'b000000) begin failures++; $display("FAIL reset_async: status=%b expected 000000", status()); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (status() !== 6'b000000) begin failures++; $display("FAIL reset_stays_idle: status=%b expected 000000", status()); end
    endtask

    task automatic test_nominal();
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h12345678, 0);
        checks++;
        if (status() !== 6'b100001) begin failures++; $display("FAIL nominal_w0_status: status=%b expected 100001", status()); end
        checks++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h12345678) begin failures++; $display("FAIL nominal_w0: addr=%h data=%h expected 00 12345678", bus.mem_addr, bus.mem_wdata); end
        send_word(32'h9ABCDEF0, 0);
        checks++;
        if (status() !== 6'b100001) begin failures++; $display("FAIL nominal_w1_status: status=%b expected 100001", status()); end
        checks++;
        if (bus.mem_addr !== 8'h01 || bus.mem_wdata !== 32'h9ABCDEF0) begin failures++; $display("FAIL nominal_w1: addr=%h data=%h expected 01 9abcdef0", bus.mem_addr, bus.mem_wdata); end
        @(posedge clk); #1;
        checks++;
        if (status() !== 6'b010100) begin failures++; $display("FAIL nominal_done: status=%b expected 010100", status()); end
        checks++;
        if (bus.mem_addr !== 8'h01 || bus.mem_wdata !== 32'h9ABCDEF0) begin failures++; $display("FAIL nominal_hold: addr=%h data=%h expected 01 9abcdef0", bus.mem_addr, bus.mem_wdata); end
        checks++;
        if (wq.size() != 2) begin
            failures++; $display("FAIL nominal_count: writes=%0d expected 2", wq.size());
        end else if (wq[0] !== {8'h00, 32'h12345678} || wq[1] !== {8'h01, 32'h9ABCDEF0}) begin
            failures++; $display("FAIL nominal_log: got %h %h expected 0012345678 019abcdef0", wq[0], wq[1]);
        end
    endtask

    task automatic test_zero_len();
        wq.delete();
        pulse_start();
        checks++;
        if (status() !== 6'b100010) begin failures++; $display("FAIL restart_from_done: status=%b expected 100010", status()); end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++;
        if (status() !== 6'b010100) begin failures++; $display("FAIL zero_len_done: status=%b expected 010100", status()); end
        checks++;
        if (wq.size() != 0) begin failures++; $display("FAIL zero_len_writes: writes=%0d expected 0", wq.size()); end
    endtask

    task automatic test_oversize();
        wq.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        checks++;
        if (status() !== 6'b001000) begin failures++; $display("FAIL oversize_err: status=%b expected 001000", status()); end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (status() !== 6'b001000 || wq.size() != 0) begin failures++; $display("FAIL oversize_hold: status=%b writes=%0d expected 001000 0", status(), wq.size()); end
        pulse_start();
        checks++;
        if (status() !== 6'b100010) begin failures++; $display("FAIL oversize_restart: status=%b expected 100010", status()); end
    endtask

    task automatic test_full_depth();
        logic [7:0]  w8;
        logic [31:0] exp_word;
        wq.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        checks++;
        if (status() !== 6'b100010) begin failures++; $display("FAIL full_depth_accept: status=%b expected 100010", status()); end
        for (int w = 0; w < 256; w++) begin
            w8 = 8'(w);
            send_word({w8, ~w8, w8 ^ 8'h5A, 8'hC3}, 0);
        end
        checks++;
        if (status() !== 6'b100001 || bus.mem_addr !== 8'hFF) begin failures++; $display("FAIL full_depth_last: status=%b addr=%h expected 100001 ff", status(), bus.mem_addr); end
        @(posedge clk); #1;
        checks++;
        if (status() !== 6'b010100) begin failures++; $display("FAIL full_depth_done: status=%b expected 010100", status()); end
        checks++;
        if (wq.size() != 256) begin
            failures++; $display("FAIL full_depth_count: writes=%0d expected 256", wq.size());
        end else begin
            for (int w = 0; w < 256; w++) begin
                w8 = 8'(w);
                exp_word = {w8, ~w8, w8 ^ 8'h5A, 8'hC3};
                checks++;
                if (wq[w] !== {w8, exp_word}) begin failures++; $display("FAIL full_depth_word%0d: got %h expected %h", w, wq[w], {w8, exp_word}); end
            end
        end
    endtask

    task automatic test_flow_control();
        logic [31:0] img [3];
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h01020304;
        img[2] = 32'hA5A55A5A;
        wq.delete();
        pulse_start();
        send_byte(8'h00, 2);
        send_byte(8'h03, 3);
        for (int i = 0; i < 3; i++) send_word(img[i], 3);
        @(posedge clk); #1;
        checks++;
        if (status() !== 6'b010100) begin failures++; $display("FAIL flow_done: status=%b expected 010100", status()); end
        checks++;
        if (wq.size() != 3) begin
            failures++; $display("FAIL flow_count: writes=%0d expected 3", wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq[i] !== {8'(i), img[i]}) begin failures++; $display("FAIL flow_word%0d: got %h expected %h", i, wq[i], {8'(i), img[i]}); end
            end
        end
    endtask

    task automatic test_reset_midload();
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (status() !== 6'b000000) begin failures++; $display("FAIL midload_reset: status=%b expected 000000", status()); end
        checks++;
        if (wq.size() != 1 || wq[0] !== {8'h00, 32'h11223344}) begin failures++; $display("FAIL midload_writes: writes=%0d first=%h expected 1 0011223344", wq.size(), (wq.size() > 0) ? wq[0] : 40'h0); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (status() !== 6'b000000) begin failures++; $display("FAIL midload_idle: status=%b expected 000000", status()); end
    endtask

    task automatic test_start_ignored();
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        pulse_start();
        checks++;
        if (status() !== 6'b100010) begin failures++; $display("FAIL start_in_data: status=%b expected 100010", status()); end
        send_byte(8'hEF, 0);
        send_byte(8'h01, 0);
        checks++;
        if (status() !== 6'b100001 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'hABCDEF01) begin
            failures++; $display("FAIL start_ignored_write: status=%b addr=%h data=%h expected 100001 00 abcdef01", status(), bus.mem_addr, bus.mem_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (status() !== 6'b010100 || wq.size() != 1) begin failures++; $display("FAIL start_ignored_done: status=%b writes=%0d expected 010100 1", status(), wq.size()); end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_nominal();
        test_zero_len();
        test_oversize();
        test_full_depth();
        test_flow_control();
        test_reset_midload();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
